// File: rtl/pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_rst_seq
// Brief    : PLL reset pulse, lock qualification and downstream reset release.
//            Define PLL_RST_SEQ_TIMEOUT_EN to add the WAIT_LOCK retry timeout.
// Revision : 1.0 - initial release
// ============================================================================
module pll_rst_seq #(
    parameter int PLLRST_CYC  = 8,
    parameter int LOCK_FILT   = 16,
    parameter int HOLD_CYC    = 1024,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       rst_out,
    output logic       ready,
    output logic [7:0] relock_cnt,
    output logic [1:0] state
);

    localparam int c_prst_w = (PLLRST_CYC > 1) ? $clog2(PLLRST_CYC) : 1;
    localparam int c_filt_w = (LOCK_FILT  > 1) ? $clog2(LOCK_FILT)  : 1;
    localparam int c_hold_w = (HOLD_CYC   > 1) ? $clog2(HOLD_CYC)   : 1;

    localparam logic [c_prst_w-1:0] c_prst_last = c_prst_w'(PLLRST_CYC - 1);
    localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(LOCK_FILT - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sync1;
    logic                r_sync2;
    logic                w_lock_s;
    logic [c_filt_w-1:0] r_filt_cnt;
    logic                r_filt_done;
    logic                w_lock_f;
    logic [c_prst_w-1:0] r_prst_cnt;
    logic                w_prst_done;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                w_hold_done;
    logic                w_timeout;
    logic                r_pll_rst;
    logic                r_rst_out;
    logic                r_ready;
    logic [7:0]          r_relock;

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s = r_sync2;

    // Lock is accepted after LOCK_FILT high cycles but dropped combinationally
    // the moment the synchronised input goes low.
    always_ff @(posedge clkin) begin
        if (rst || r_state == S_PLL_RST || !w_lock_s) begin
            r_filt_cnt  <= '0;
            r_filt_done <= 1'b0;
        end else if (r_filt_cnt == c_filt_last) begin
            r_filt_done <= 1'b1;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_lock_f = w_lock_s & r_filt_done;

    always_ff @(posedge clkin) begin
        if (rst || r_state != S_PLL_RST) begin
            r_prst_cnt <= '0;
        end else if (!w_prst_done) begin
            r_prst_cnt <= r_prst_cnt + 1'b1;
        end
    end

    assign w_prst_done = (r_prst_cnt == c_prst_last);

    always_ff @(posedge clkin) begin
        if (rst || r_state != S_HOLD || !w_lock_f) begin
            r_hold_cnt <= '0;
        end else if (!w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    assign w_hold_done = (r_hold_cnt == c_hold_last);

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    localparam int c_to_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYC - 1);

    logic [c_to_w-1:0] r_to_cnt;

    always_ff @(posedge clkin) begin
        if (rst || r_state != S_WAIT_LOCK || w_lock_f) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_to_last) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_to_cnt == c_to_last);
`else
    // Without the retry timer WAIT_LOCK waits forever; TIMEOUT_CYC is inert.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC > 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_PLL_RST:   if (w_prst_done) w_state_nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (w_lock_f)       w_state_nxt = S_HOLD;
                else if (w_timeout) w_state_nxt = S_PLL_RST;
            end
            S_HOLD: begin
                if (!w_lock_f)        w_state_nxt = S_WAIT_LOCK;
                else if (w_hold_done) w_state_nxt = S_RUN;
            end
            S_RUN:       if (!w_lock_f) w_state_nxt = S_PLL_RST;
            default:     w_state_nxt = S_PLL_RST;
        endcase
    end

    // Outputs are decoded from the next state so they stay aligned with r_state.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state   <= S_PLL_RST;
            r_pll_rst <= 1'b1;
            r_rst_out <= 1'b1;
            r_ready   <= 1'b0;
            r_relock  <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pll_rst <= (w_state_nxt == S_PLL_RST);
            r_rst_out <= (w_state_nxt != S_RUN);
            r_ready   <= (w_state_nxt == S_RUN);
            if (r_state == S_RUN && !w_lock_f && r_relock != 8'hFF) begin
                r_relock <= r_relock + 8'd1;
            end
        end
    end

    assign pll_rst    = r_pll_rst;
    assign rst_out    = r_rst_out;
    assign ready      = r_ready;
    assign relock_cnt = r_relock;
    assign state      = r_state;

endmodule

`default_nettype wire
